warp_fetch: RTL and testbench



---
 rtl/warp_pkg.sv | 22 ++
 rtl/warp_fetch_if.sv | 38 +++
 rtl/warp_fetch_buf.sv | 77 +++++++
 rtl/warp_fetch.sv | 129 ++++++++++++
 tb/tb_warp_fetch.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/warp_pkg.sv
// Shared definitions for the warp fetch stage: widths, FSM encoding, alignment helpers.
package warp_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] DW_ALIGN_MASK = ~64'h7;
    localparam logic [XLEN-1:0] DW_BYTES      = 64'd8;
    localparam logic [XLEN-1:0] INST_BYTES    = 64'd4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StDrain = 2'd2
    } fetch_state_e;

    // Round a PC down to the containing doubleword.
    function automatic logic [XLEN-1:0] dw_align(input logic [XLEN-1:0] pc);
        return pc & DW_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/warp_fetch_if.sv
// Fetch-stage bus bundle: backend redirect, icache request/response, decode handshake.
// o_fault exists only when WARP_FETCH_MISALIGN_FAULT_EN is defined.
interface warp_fetch_if;
    import warp_pkg::*;

    logic            i_redirect_valid;
    logic [XLEN-1:0] i_redirect_pc;
    logic            o_req_valid;
    logic [XLEN-1:0] o_req_raddr;
    logic            i_res_valid;
    logic [XLEN-1:0] i_res_rdata;
    logic            o_inst_valid;
    logic [ILEN-1:0] o_inst;
    logic [XLEN-1:0] o_inst_pc;
    logic            i_inst_ready;
`ifdef WARP_FETCH_MISALIGN_FAULT_EN
    logic            o_fault;

    modport master (
        input  i_redirect_valid, i_redirect_pc, i_res_valid, i_res_rdata, i_inst_ready,
        output o_req_valid, o_req_raddr, o_inst_valid, o_inst, o_inst_pc, o_fault
    );
    modport slave (
        output i_redirect_valid, i_redirect_pc, i_res_valid, i_res_rdata, i_inst_ready,
        input  o_req_valid, o_req_raddr, o_inst_valid, o_inst, o_inst_pc, o_fault
    );
`else
    modport master (
        input  i_redirect_valid, i_redirect_pc, i_res_valid, i_res_rdata, i_inst_ready,
        output o_req_valid, o_req_raddr, o_inst_valid, o_inst, o_inst_pc
    );
    modport slave (
        output i_redirect_valid, i_redirect_pc, i_res_valid, i_res_rdata, i_inst_ready,
        input  o_req_valid, o_req_raddr, o_inst_valid, o_inst, o_inst_pc
    );
`endif

endinterface

// File: rtl/warp_fetch_buf.sv
// Circular {pc, inst} buffer with flush, up to two pushes and one pop per cycle.
// Head outputs read zero while the buffer is empty.
module warp_fetch_buf
    import warp_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic                       i_push0,
    input  logic                       i_push1,
    input  logic [XLEN-1:0]            i_pc0,
    input  logic [ILEN-1:0]            i_inst0,
    input  logic [XLEN-1:0]            i_pc1,
    input  logic [ILEN-1:0]            i_inst1,
    input  logic                       i_pop,
    output logic                       o_valid,
    output logic [XLEN-1:0]            o_pc,
    output logic [ILEN-1:0]            o_inst,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [XLEN-1:0]  r_pc_mem   [DEPTH];
    logic [ILEN-1:0]  r_inst_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic             w_valid;
    logic             w_pop;
    logic             w_wr0;
    logic             w_wr1;
    logic [PTR_W-1:0] w_wptr1;
    logic [CNT_W-1:0] w_push_n;

    assign w_valid  = (r_count != '0);
    assign w_pop    = i_pop & w_valid;
    assign w_wr0    = i_push0 & ~i_flush;
    assign w_wr1    = i_push0 & i_push1 & ~i_flush;
    assign w_wptr1  = r_wptr + PTR_W'(1);
    assign w_push_n = CNT_W'(w_wr0) + CNT_W'(w_wr1);

    // Pointers and occupancy; flush empties the buffer and beats any push/pop.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + PTR_W'(w_push_n);
            r_rptr  <= r_rptr + PTR_W'(w_pop);
            r_count <= r_count + w_push_n - CNT_W'(w_pop);
        end
    end

    // Entry storage; the second push lands in the slot after the first.
    always_ff @(posedge i_clk) begin
        if (w_wr0) begin
            r_pc_mem[r_wptr]   <= i_pc0;
            r_inst_mem[r_wptr] <= i_inst0;
        end
        if (w_wr1) begin
            r_pc_mem[w_wptr1]   <= i_pc1;
            r_inst_mem[w_wptr1] <= i_inst1;
        end
    end

    assign o_valid = w_valid;
    assign o_pc    = w_valid ? r_pc_mem[r_rptr]   : '0;
    assign o_inst  = w_valid ? r_inst_mem[r_rptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/warp_fetch.sv
// Instruction fetch stage: one icache line request at a time, doubleword split into
// 32-bit instructions, buffered for decode. Redirects flush the buffer and drop any
// in-flight response. Optional misaligned-redirect fault: WARP_FETCH_MISALIGN_FAULT_EN.
module warp_fetch
    import warp_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 64'h0000_0000_8000_0000,
    parameter int unsigned     BUF_DEPTH = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    warp_fetch_if.master  io_bus
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH+1);

    fetch_state_e     r_state;
    logic [XLEN-1:0]  r_fetch_pc;
    logic             r_req_valid;
    logic [XLEN-1:0]  r_req_raddr;

    logic             w_redirect;
    logic [XLEN-1:0]  w_redirect_pc;
    logic             w_block_req;
    logic             w_pop;
    logic [CNT_W-1:0] w_count;
    logic [31:0]      w_free;
    logic             w_can_issue;
    logic             w_take_res;
    logic             w_push1;
    logic [ILEN-1:0]  w_inst0;

    assign w_redirect = io_bus.i_redirect_valid;

`ifdef WARP_FETCH_MISALIGN_FAULT_EN
    logic r_fault;

    assign w_redirect_pc = io_bus.i_redirect_pc;
    assign w_block_req   = r_fault;
    assign io_bus.o_fault = r_fault;

    // Sticky fault: set by a misaligned redirect, cleared by an aligned one.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_fault <= 1'b0;
        end else if (w_redirect) begin
            r_fault <= (io_bus.i_redirect_pc[1:0] != 2'b00);
        end
    end
`else
    assign w_redirect_pc = {io_bus.i_redirect_pc[XLEN-1:2], 2'b00};
    assign w_block_req   = 1'b0;
`endif

    assign w_pop = io_bus.o_inst_valid & io_bus.i_inst_ready;

    // Free space is judged after this cycle's pop so a request never overflows the push.
    assign w_free      = BUF_DEPTH - 32'(w_count) + 32'(w_pop);
    assign w_can_issue = (w_free >= 32'd2) && !w_block_req;

    // A redirect in the same cycle means the response belongs to the old stream.
    assign w_take_res = (r_state == StWait) && io_bus.i_res_valid && !w_redirect;
    assign w_push1    = w_take_res && !r_fetch_pc[2];
    assign w_inst0    = r_fetch_pc[2] ? io_bus.i_res_rdata[63:32] : io_bus.i_res_rdata[31:0];

    // Fetch FSM with registered request outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_fetch_pc  <= RESET_PC;
            r_req_valid <= 1'b0;
            r_req_raddr <= '0;
        end else begin
            r_req_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_redirect) begin
                        r_fetch_pc <= w_redirect_pc;
                    end else if (w_can_issue) begin
                        r_req_valid <= 1'b1;
                        r_req_raddr <= dw_align(r_fetch_pc);
                        r_state     <= StWait;
                    end
                end
                StWait: begin
                    if (w_redirect) begin
                        r_fetch_pc <= w_redirect_pc;
                        r_state    <= io_bus.i_res_valid ? StIdle : StDrain;
                    end else if (io_bus.i_res_valid) begin
                        r_fetch_pc <= dw_align(r_fetch_pc) + DW_BYTES;
                        r_state    <= StIdle;
                    end
                end
                StDrain: begin
                    if (w_redirect) begin
                        r_fetch_pc <= w_redirect_pc;
                    end
                    if (io_bus.i_res_valid) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_bus.o_req_valid = r_req_valid;
    assign io_bus.o_req_raddr = r_req_raddr;

    warp_fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (w_redirect),
        .i_push0 (w_take_res),
        .i_push1 (w_push1),
        .i_pc0   (r_fetch_pc),
        .i_inst0 (w_inst0),
        .i_pc1   (r_fetch_pc + INST_BYTES),
        .i_inst1 (io_bus.i_res_rdata[63:32]),
        .i_pop   (w_pop),
        .o_valid (io_bus.o_inst_valid),
        .o_pc    (io_bus.o_inst_pc),
        .o_inst  (io_bus.o_inst),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_warp_fetch.sv
// Bench for warp_fetch: icache stub, scoreboard queues for requests and instructions,
// and a monitor that pops and compares whenever the DUT presents a request or a pop.
module tb_warp_fetch;
    import warp_pkg::*;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    warp_fetch_if bus ();

    warp_fetch #(
        .RESET_PC  (64'h0000_0000_8000_0000),
        .BUF_DEPTH (4)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [63:0] req_q[$];
    exp_t        inst_q[$];

    int unsigned lat = 9;
    logic        stub_pending = 1'b0;
    int unsigned stub_cnt = 0;
    logic [63:0] stub_addr = '0;

    function automatic exp_t mk(input logic [63:0] pc, input logic [31:0] inst);
        exp_t e;
        e.pc = pc;
        e.inst = inst;
        return e;
    endfunction

    // Stub memory contents: the first line is fixed, others tag each word with its address.
    function automatic logic [63:0] dw(input logic [63:0] a);
        if (a == 64'h0000_0000_8000_0000) return 64'hBBBB_BBBB_AAAA_AAAA;
        return {32'h5A5A_0000 | (a[31:0] + 32'd4), 32'h5A5A_0000 | a[31:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    // icache stub: one outstanding request, answers lat cycles after seeing it.
    initial begin
        bus.i_res_valid = 1'b0;
        bus.i_res_rdata = '0;
        forever begin
            @(negedge clk);
            bus.i_res_valid = 1'b0;
            if (!rst_n) begin
                stub_pending = 1'b0;
            end else begin
                if (stub_pending) begin
                    if (stub_cnt == 0) begin
                        bus.i_res_valid = 1'b1;
                        bus.i_res_rdata = dw(stub_addr);
                        stub_pending = 1'b0;
                    end else begin
                        stub_cnt--;
                    end
                end
                if (bus.o_req_valid) begin
                    stub_pending = 1'b1;
                    stub_cnt = lat - 1;
                    stub_addr = bus.o_req_raddr;
                end
            end
        end
    end

    // Monitor: compares against queued expectations; a redirect cycle discards the head.
    initial begin
        logic [63:0] ea;
        exp_t        ei;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n) begin
                if (bus.o_req_valid && req_q.size() != 0) begin
                    ea = req_q.pop_front();
                    chk("req_addr", bus.o_req_raddr, ea);
                end
                if (bus.o_inst_valid && bus.i_inst_ready && !bus.i_redirect_valid
                    && inst_q.size() != 0) begin
                    ei = inst_q.pop_front();
                    chk("inst_word", {32'h0, bus.o_inst}, {32'h0, ei.inst});
                    chk("inst_pc", bus.o_inst_pc, ei.pc);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic wait_res(input string name);
        int unsigned k = 0;
        step();
        while (bus.i_res_valid !== 1'b1 && k < 100) begin
            step();
            k++;
        end
        n_checks++;
        if (bus.i_res_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL %s: no response seen, required one", name);
        end
    endtask

    task automatic wait_req(input string name);
        int unsigned k = 0;
        step();
        while (bus.o_req_valid !== 1'b1 && k < 100) begin
            step();
            k++;
        end
        n_checks++;
        if (bus.o_req_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL %s: no request seen, required one", name);
        end
    endtask

    task automatic wait_req_q_empty(input string name);
        int unsigned k = 0;
        while (req_q.size() != 0 && k < 200) begin
            step();
            k++;
        end
        n_checks++;
        if (req_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s: %0d requests still pending, required 0", name, req_q.size());
            req_q.delete();
        end
    endtask

    task automatic wait_drained(input string name);
        int unsigned k = 0;
        while ((req_q.size() != 0 || inst_q.size() != 0) && k < 200) begin
            step();
            k++;
        end
        n_checks++;
        if (req_q.size() != 0 || inst_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s: pending req=%0d inst=%0d, required 0 and 0", name,
                     req_q.size(), inst_q.size());
            req_q.delete();
            inst_q.delete();
        end
    endtask

    // Caller sits at negedge+2; redirect is sampled at the next posedge.
    task automatic redirect(input logic [63:0] pc, input logic rdy);
        bus.i_inst_ready     = rdy;
        bus.i_redirect_valid = 1'b1;
        bus.i_redirect_pc    = pc;
        req_q.delete();
        inst_q.delete();
        step();
        bus.i_redirect_valid = 1'b0;
        chk("inst_valid_after_redirect", bus.o_inst_valid, 1'b0);
        chk("req_valid_after_redirect", bus.o_req_valid, 1'b0);
    endtask

    initial begin
        bus.i_redirect_valid = 1'b0;
        bus.i_redirect_pc    = '0;
        bus.i_inst_ready     = 1'b1;
        rst_n = 1'b0;
        repeat (3) step();

        chk("rst_req_valid", bus.o_req_valid, 1'b0);
        chk("rst_req_raddr", bus.o_req_raddr, 64'h0);
        chk("rst_inst_valid", bus.o_inst_valid, 1'b0);
        chk("rst_inst", {32'h0, bus.o_inst}, 64'h0);
        chk("rst_inst_pc", bus.o_inst_pc, 64'h0);
`ifdef WARP_FETCH_MISALIGN_FAULT_EN
        chk("rst_fault", bus.o_fault, 1'b0);
`endif

        // Reset fetch stream from 0x8000_0000.
        req_q.push_back(64'h8000_0000);
        req_q.push_back(64'h8000_0008);
        inst_q.push_back(mk(64'h8000_0000, 32'hAAAA_AAAA));
        inst_q.push_back(mk(64'h8000_0004, 32'hBBBB_BBBB));
        rst_n = 1'b1;
        wait_drained("reset_stream");
        lat = 4;

        // Redirect while IDLE (cycle after a response) to an odd-word PC.
        wait_res("idle_wait_res");
        step();
        redirect(64'h1004, 1'b1);
        req_q.push_back(64'h1000);
        req_q.push_back(64'h1008);
        inst_q.push_back(mk(64'h1004, 32'h5A5A_1004));
        step();
        chk("req_latency_idle", bus.o_req_valid, 1'b1);
        wait_drained("idle_redirect");

        // Redirect while WAIT: in-flight response must be dropped.
        wait_req("wait_req_seen");
        redirect(64'h2000, 1'b1);
        req_q.push_back(64'h2000);
        req_q.push_back(64'h2008);
        inst_q.push_back(mk(64'h2000, 32'h5A5A_2000));
        inst_q.push_back(mk(64'h2004, 32'h5A5A_2004));
        wait_drained("wait_redirect");

        // Back-pressure: fill all four entries, then no further requests.
        step();
        redirect(64'h4000, 1'b0);
        req_q.push_back(64'h4000);
        req_q.push_back(64'h4008);
        inst_q.push_back(mk(64'h4000, 32'h5A5A_4000));
        inst_q.push_back(mk(64'h4004, 32'h5A5A_4004));
        inst_q.push_back(mk(64'h4008, 32'h5A5A_4008));
        inst_q.push_back(mk(64'h400C, 32'h5A5A_400C));
        wait_req_q_empty("stall_reqs");
        repeat (lat + 3) step();
        for (int i = 0; i < 12; i++) begin
            chk("stall_no_req", bus.o_req_valid, 1'b0);
            chk("stall_head_valid", bus.o_inst_valid, 1'b1);
            chk("stall_head_inst", {32'h0, bus.o_inst}, 64'h5A5A_4000);
            chk("stall_head_pc", bus.o_inst_pc, 64'h4000);
            step();
        end
        req_q.push_back(64'h4010);
        inst_q.push_back(mk(64'h4010, 32'h5A5A_4010));
        inst_q.push_back(mk(64'h4014, 32'h5A5A_4014));
        bus.i_inst_ready = 1'b1;
        step();
        chk("pop_per_cycle_1", bus.o_inst_pc, 64'h4004);
        step();
        chk("pop_per_cycle_2", bus.o_inst_pc, 64'h4008);
        wait_drained("stall_release");

        // Redirect coincident with a response and a pop.
        step();
        redirect(64'h5000, 1'b0);
        req_q.push_back(64'h5000);
        req_q.push_back(64'h5008);
        wait_req_q_empty("coinc_reqs");
        wait_res("coinc_wait_res");
        chk("coinc_head_valid", bus.o_inst_valid, 1'b1);
        redirect(64'h6000, 1'b1);
        req_q.push_back(64'h6000);
        inst_q.push_back(mk(64'h6000, 32'h5A5A_6000));
        inst_q.push_back(mk(64'h6004, 32'h5A5A_6004));
        step();
        chk("req_latency_coinc", bus.o_req_valid, 1'b1);
        wait_drained("coinc_redirect");

`ifdef WARP_FETCH_MISALIGN_FAULT_EN
        // Misaligned redirect faults and blocks fetch; aligned redirect resumes.
        step();
        redirect(64'h3002, 1'b1);
        for (int i = 0; i < 12; i++) begin
            chk("fault_set", bus.o_fault, 1'b1);
            chk("fault_no_req", bus.o_req_valid, 1'b0);
            step();
        end
        redirect(64'h3000, 1'b1);
        chk("fault_clear", bus.o_fault, 1'b0);
        req_q.push_back(64'h3000);
        inst_q.push_back(mk(64'h3000, 32'h5A5A_3000));
        inst_q.push_back(mk(64'h3004, 32'h5A5A_3004));
        step();
        chk("fault_resume_req", bus.o_req_valid, 1'b1);
        wait_drained("fault_resume");
`else
        // Low PC bits of a redirect are ignored.
        step();
        redirect(64'h3002, 1'b1);
        req_q.push_back(64'h3000);
        inst_q.push_back(mk(64'h3000, 32'h5A5A_3000));
        inst_q.push_back(mk(64'h3004, 32'h5A5A_3004));
        wait_drained("misalign_forced");
`endif

        // PC increment wraps modulo 2^64.
        step();
        redirect(64'hFFFF_FFFF_FFFF_FFF8, 1'b1);
        req_q.push_back(64'hFFFF_FFFF_FFFF_FFF8);
        req_q.push_back(64'h0);
        inst_q.push_back(mk(64'hFFFF_FFFF_FFFF_FFF8, 32'hFFFF_FFF8));
        inst_q.push_back(mk(64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC));
        wait_drained("pc_wrap");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
